// File: rtl/truth_table_capture.sv
// rtl/truth_table_capture.sv - captures a swept DUT truth table, tracks coverage, counts errors.
// Optional MISR signature over accepted samples: define TT_CAPTURE_SIGNATURE_EN.
module truth_table_capture #(
    parameter int               W      = 4,
    parameter logic [2**W-1:0]  EXPECT = 16'h8000,
    parameter int               ERR_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               smp_valid_i,
    input  logic [W-1:0]       smp_a_i,
    input  logic               smp_y_i,
    input  logic               rd_en_i,
    input  logic [W-1:0]       rd_addr_i,
    output logic               rd_data_o,
    output logic               rd_valid_o,
    output logic [2**W-1:0]    table_q_o,
    output logic [2**W-1:0]    covered_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               mismatch_o,
    output logic [ERR_W-1:0]   err_cnt_o,
    output logic [15:0]        sig_o
);
    localparam int N = 2**W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       table_q, table_d;
    logic [N-1:0]       cov_q, cov_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_data_q, rd_valid_q;
    logic               accept;
    logic               err_inc;

    // start always wins: a sample presented in the same cycle is dropped
    assign accept = smp_valid_i && (state_q == ST_CAPTURE) && !start_i;

    always_comb begin
        state_d = state_q;
        table_d = table_q;
        cov_d   = cov_q;
        err_d   = err_q;
        err_inc = 1'b0;
        if (start_i) begin
            state_d = ST_CAPTURE;
            table_d = '0;
            cov_d   = '0;
            err_d   = '0;
        end else begin
            if (state_q == ST_CAPTURE && (&cov_q)) begin
                state_d = ST_DONE;
            end
            if (accept) begin
                if (!cov_q[smp_a_i]) begin
                    table_d[smp_a_i] = smp_y_i;
                    cov_d[smp_a_i]   = 1'b1;
                    err_inc          = (smp_y_i != EXPECT[smp_a_i]);
                end else begin
                    // repeat hit: first capture wins, disagreement flags a non-deterministic DUT
                    err_inc = (smp_y_i != table_q[smp_a_i]);
                end
            end
            if (err_inc && (err_q != {ERR_W{1'b1}})) begin
                err_d = err_q + 1'b1;
            end
        end
        busy_d = (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            table_q    <= '0;
            cov_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            table_q    <= table_d;
            cov_q      <= cov_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= table_q[rd_addr_i];
            end
        end
    end

`ifdef TT_CAPTURE_SIGNATURE_EN
    logic [15:0] sig_q, sig_d;
    logic        fb;

    always_comb begin
        fb    = sig_q[15] ^ smp_y_i;
        sig_d = sig_q;
        if (start_i) begin
            sig_d = 16'hFFFF;
        end else if (accept) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 16'hFFFF;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;
`else
    assign sig_o = 16'h0000;
`endif

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign table_q_o  = table_q;
    assign covered_o  = cov_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_cnt_o  = err_q;
    assign mismatch_o = (err_q != '0);

endmodule

// File: tb/tb_truth_table_capture.sv
// tb/tb_truth_table_capture.sv - scoreboard bench for truth_table_capture.
module tb_truth_table_capture;
    localparam int W     = 4;
    localparam int ERR_W = 2;

    logic              clk = 1'b0;
    logic              rst, start, smp_valid, smp_y, rd_en;
    logic [W-1:0]      smp_a, rd_addr;
    logic              rd_data, rd_valid, busy, done, mismatch;
    logic [15:0]       tbl, cov, sig;
    logic [ERR_W-1:0]  err_cnt;

    always #5 clk = ~clk;

    truth_table_capture #(.W(W), .EXPECT(16'h8000), .ERR_W(ERR_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .smp_valid_i(smp_valid),
        .smp_a_i(smp_a), .smp_y_i(smp_y), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .table_q_o(tbl), .covered_o(cov),
        .busy_o(busy), .done_o(done), .mismatch_o(mismatch), .err_cnt_o(err_cnt),
        .sig_o(sig)
    );

    typedef struct packed {
        logic        bit_v;
        logic [15:0] tbl;
        logic [15:0] cov;
        logic [1:0]  err;
        logic        busy;
        logic        done;
        logic [15:0] sig;
    } exp_t;

    exp_t        rd_q[$];
    int          done_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] m_sig = 16'hFFFF;
    logic        done_prev = 1'b0;
    exp_t        e_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] s, input logic y);
        logic f;
        f = s[15] ^ y;
        return {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [15:0] exp_sig();
`ifdef TT_CAPTURE_SIGNATURE_EN
        return m_sig;
`else
        return 16'h0000;
`endif
    endfunction

    // monitor: compares whenever the DUT presents read data or raises done
    always @(negedge clk) begin
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rd_valid actual=1 required=0");
            end else begin
                e_m = rd_q.pop_front();
                cmp("rd_data",  {31'd0, rd_data}, {31'd0, e_m.bit_v});
                cmp("table_q",  {16'd0, tbl},     {16'd0, e_m.tbl});
                cmp("covered",  {16'd0, cov},     {16'd0, e_m.cov});
                cmp("err_cnt",  {30'd0, err_cnt}, {30'd0, e_m.err});
                cmp("mismatch", {31'd0, mismatch}, {31'd0, (e_m.err != 2'd0)});
                cmp("busy",     {31'd0, busy},    {31'd0, e_m.busy});
                cmp("done",     {31'd0, done},    {31'd0, e_m.done});
                cmp("sig",      {16'd0, sig},     {16'd0, e_m.sig});
            end
        end
        if (done && !done_prev) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done_rise actual=%0d required=none", cyc);
            end else begin
                cmp("done_cycle", cyc, done_q.pop_front());
            end
        end
        done_prev <= done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int a, input logic y, input bit acc);
        smp_valid = 1'b1; smp_a = a[W-1:0]; smp_y = y;
        tick();
        smp_valid = 1'b0;
        if (acc) m_sig = crc_step(m_sig, y);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_sig = 16'hFFFF;
    endtask

    task automatic rd(input int a, input logic b, input logic [15:0] t, input logic [15:0] c,
                      input logic [1:0] e, input logic bz, input logic dn);
        rd_q.push_back('{bit_v: b, tbl: t, cov: c, err: e, busy: bz, done: dn, sig: exp_sig()});
        rd_en = 1'b1; rd_addr = a[W-1:0];
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic sweep_up(input logic [15:0] ys);
        for (int a = 0; a < 16; a++) sample(a, ys[a], 1'b1);
        done_q.push_back(cyc + 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; smp_valid = 1'b0; smp_y = 1'b0; smp_a = '0;
        rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // T1: idle reset state, samples in IDLE ignored
        rd(0, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);
        sample(3, 1'b1, 1'b0);
        sample(15, 1'b1, 1'b0);
        rd(3, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b0, 1'b0);

        // T2: clean sweep, then a DONE-state sample must be ignored
        do_start();
        sweep_up(16'h8000);
        rd(15, 1'b1, 16'h8000, 16'hFFFF, 2'd0, 1'b0, 1'b1);
        sample(5, 1'b1, 1'b0);
        rd(5, 1'b0, 16'h8000, 16'hFFFF, 2'd0, 1'b0, 1'b1);

        // T3: faulty DUT at A=3
        do_start();
        sweep_up(16'h8008);
        rd(3, 1'b1, 16'h8008, 16'hFFFF, 2'd1, 1'b0, 1'b1);

        // T4: descending sweep then conflicting repeat of A=5
        do_start();
        for (int a = 15; a >= 0; a--) sample(a, (a == 15), 1'b1);
        done_q.push_back(cyc + 1);
        sample(5, 1'b1, 1'b1);
        rd(5, 1'b0, 16'h8000, 16'hFFFF, 2'd1, 1'b0, 1'b1);

        // async reset mid-sweep
        do_start();
        for (int a = 0; a < 5; a++) sample(a, (a == 2), 1'b1);
        rd(2, 1'b1, 16'h0004, 16'h001F, 2'd1, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        m_sig = 16'hFFFF;
        cmp("rst_table",    {16'd0, tbl},      32'd0);
        cmp("rst_covered",  {16'd0, cov},      32'd0);
        cmp("rst_err",      {30'd0, err_cnt},  32'd0);
        cmp("rst_mismatch", {31'd0, mismatch}, 32'd0);
        cmp("rst_busy",     {31'd0, busy},     32'd0);
        cmp("rst_done",     {31'd0, done},     32'd0);
        cmp("rst_rd_data",  {31'd0, rd_data},  32'd0);
        cmp("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        cmp("rst_sig",      {16'd0, sig},      {16'd0, exp_sig()});
        tick();
        rst = 1'b0;
        tick();

        // T5: restart colliding with a sample, then full sweep
        do_start();
        for (int a = 0; a < 7; a++) sample(a, 1'b0, 1'b1);
        start = 1'b1; smp_valid = 1'b1; smp_a = 4'd7; smp_y = 1'b1;
        tick();
        start = 1'b0; smp_valid = 1'b0;
        m_sig = 16'hFFFF;
        rd(7, 1'b0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0);
        sweep_up(16'h8000);
        rd(7, 1'b0, 16'h8000, 16'hFFFF, 2'd0, 1'b0, 1'b1);

        // T6: every capture wrong, counter saturates at 3
        do_start();
        sweep_up(16'h7FFF);
        rd(0, 1'b1, 16'h7FFF, 16'hFFFF, 2'd3, 1'b0, 1'b1);

        tick(); tick();
        if (rd_q.size() != 0 || done_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL pending_expectations actual=%0d required=0", rd_q.size() + done_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
